// File: rtl/fft_frame_counter.sv
// Start/stop beat counter that sequences FFT frames: counts valid beats up to a
// threshold latched at start. Optional frame counter enabled by FFT_CNT_FRAME_CNT_EN.
module fft_frame_counter #(
  parameter int CNT_W = 8,
  parameter int FRM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] thresh,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             not_zero,
  output logic             full,
  output logic             busy,
  output logic             err,
  output logic [FRM_W-1:0] frame_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_thr;
  logic [CNT_W-1:0] w_thr_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_full;
  logic             w_full_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_not_zero;
  logic             r_busy;
  logic             w_last_beat;

  // cnt never exceeds r_thr-1, so the equality test alone marks the frame end
  assign w_last_beat = (r_cnt == (r_thr - CNT_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_thr_nxt   = r_thr;
    w_mode_nxt  = r_mode;
    w_full_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!stop && start) begin
          if (thresh != '0) begin
            w_thr_nxt   = thresh;
            w_mode_nxt  = mode;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (valid) begin
          if (w_last_beat) begin
            w_cnt_nxt   = '0;
            w_full_nxt  = 1'b1;
            w_state_nxt = r_mode ? RUN : IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_thr      <= '0;
      r_mode     <= 1'b0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_not_zero <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_thr      <= w_thr_nxt;
      r_mode     <= w_mode_nxt;
      r_full     <= w_full_nxt;
      r_err      <= w_err_nxt;
      r_not_zero <= (w_cnt_nxt != '0);
      r_busy     <= (w_state_nxt == RUN);
    end
  end

`ifdef FFT_CNT_FRAME_CNT_EN
  logic [FRM_W-1:0] r_frame_cnt;

  // Wraps naturally; only reset clears it, so stop leaves the history intact
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_full_nxt) begin
      r_frame_cnt <= r_frame_cnt + FRM_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

  assign cnt      = r_cnt;
  assign not_zero = r_not_zero;
  assign full     = r_full;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
